// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit engine: state encodings,
// control-byte bit positions and status-byte bit positions.
package uart_tx_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int UC_SEND  = 0;
    localparam int UC_PAR   = 1;
    localparam int UC_STOP2 = 2;
    localparam int UC_CLR   = 3;

    localparam int SB_BUSY    = 0;
    localparam int SB_DONE    = 1;
    localparam int SB_OVERRUN = 2;

endpackage

// File: rtl/uart_tx_engine_baud_gen.sv
// Bit-period timer: free-runs 0..CLKS_PER_BIT-1 while run is high,
// pulses bit_tick on the last count, and sits at zero while idle.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_cnt;

    assign bit_tick = run && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!run || bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter behind the CPU's uart_data/uart_ctrl registers:
// one 8N1/8E1/8N2/8E2 frame per rising edge of the send bit.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_d,
    input  logic [7:0] uart_c,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] status
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_req_prev;
    logic [7:0] r_data;
    logic       r_par_en;
    logic       r_stop2;
    logic [2:0] r_bit;
    logic [2:0] w_bit_nxt;
    logic       r_done;
    logic       r_done_flag;
    logic       r_overrun;
    logic       w_edge;
    logic       w_busy;
    logic       w_clr;
    logic       w_tick;
    logic       w_end;
    logic       w_tx;
    logic       w_unused_ctrl;

    assign w_unused_ctrl = &{1'b0, uart_c[7:4]};

    assign w_edge = uart_c[UC_SEND] && !r_req_prev;
    assign w_busy = (r_state != ST_IDLE);
    assign w_clr  = uart_c[UC_CLR];

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .run      (w_busy),
        .bit_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_end       = 1'b0;
        w_tx        = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                if (w_edge) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_tx = 1'b0;
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                w_tx = r_data[r_bit];
                if (w_tick) begin
                    w_bit_nxt = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                w_tx = ^r_data;
                if (w_tick) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // r_bit[0] marks the second stop bit of a two-stop frame
                if (w_tick) begin
                    if (r_stop2 && !r_bit[0]) begin
                        w_bit_nxt = 3'd1;
                    end else begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = ST_IDLE;
                        w_end       = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_prev  <= 1'b1;
            r_data      <= 8'h00;
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_bit       <= 3'd0;
            r_done      <= 1'b0;
            r_done_flag <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit      <= w_bit_nxt;
            r_req_prev <= uart_c[UC_SEND];
            r_done     <= w_end;
            if (!w_busy && w_edge) begin
                r_data   <= uart_d;
                r_par_en <= uart_c[UC_PAR];
                r_stop2  <= uart_c[UC_STOP2];
            end
            if (w_end) begin
                r_done_flag <= 1'b1;
            end else if (w_clr) begin
                r_done_flag <= 1'b0;
            end
            if (w_busy && w_edge) begin
                r_overrun <= 1'b1;
            end else if (w_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign tx   = w_tx;
    assign busy = w_busy;
    assign done = r_done;

    always_comb begin
        status             = 8'h00;
        status[SB_BUSY]    = w_busy;
        status[SB_DONE]    = r_done_flag;
        status[SB_OVERRUN] = r_overrun;
    end

endmodule
